riscv_imm_gen: RTL and testbench
================================

Name: riscv_imm_gen

Overview:
Registered RV64I immediate generator in the decode stage. Takes a 32-bit instruction and drives the sign-extended 64-bit immediate for its format (I/S/B/U/J), plus a format code. Downstream ALU-operand and branch-target logic consume it. One pipeline register; output follows input by one clock.

Parameters:
XLEN, 64, immediate output width; only 64 supported.

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  synchronous active-low reset
in_valid  in  1  instruction qualifier
instruction  in  32  raw instruction word
out_valid  out  1  in_valid delayed one cycle
immediate  out  XLEN  sign-extended immediate
imm_fmt  out  3  0=NONE,1=I,2=S,3=B,4=U,5=J,6=SHAMT

Behaviour:
- Reset: synchronous, sampled at rising clk while rst_n=0. Clears out_valid=0, immediate=0 and imm_fmt=NONE. Reset wins over any simultaneous input. Reset mid-stream discards the in-flight word.
- Latency: 1 cycle. Outputs registered at each edge.
- When in_valid=0, out_valid is 0 next cycle. immediate and imm_fmt hold their previous values. No backpressure.
- Decode uses opcode = instruction[6:0]:
  - LOAD 0000011, JALR 1100111, MISC-MEM 0001111, SYSTEM 1110011 -> I: sext(inst[31:20]).
  - OP-IMM 0010011: funct3 001/101 -> SHAMT, zero-extended inst[25:20]; other funct3 -> I.
  - OP-IMM-32 0011011: funct3 001/101 -> SHAMT, zero-extended inst[24:20]; other funct3 -> I.
  - STORE 0100011 -> S: sext({inst[31:25],inst[11:7]}).
  - BRANCH 1100011 -> B: sext({inst[31],inst[7],inst[30:25],inst[11:8],1'b0}).
  - LUI 0110111, AUIPC 0010111 -> U: sext({inst[31:12],12'b0}).
  - JAL 1101111 -> J: sext({inst[31],inst[19:12],inst[20],inst[30:21],1'b0}).
  - OP 0110011, OP-32 0111011 and all other opcodes -> NONE, immediate=0.
- Sign extension replicates inst[31] through bit 63 for I/S/B/U/J.
- B and J bit 0 is always 0.
- Extremes:
  - I-type 0x7FF -> 2047, 0x800 -> -2048.
  - B range is -4096..4094.
  - J range is ±1 MiB.
- No internal state besides the output registers.

Optional Feature:
IMM_ILLEGAL_EN
- Defined: adds output imm_illegal (1 bit), registered with the other outputs and reset to 0. It is 1 when in_valid=1 and the opcode is outside the recognised list above, including OP/OP-32. It is also 1 for OP-IMM funct3=001/101 when inst[31:26] is not in {000000, 010000 (101 only)}.
- Undefined: the port is absent and decode results are unchanged.

Decomposition:
- Package riscv_imm_pkg holds:
  - opcode localparams: OPC_LOAD, OPC_OP_IMM, OPC_OP_IMM32, OPC_STORE, OPC_BRANCH, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_MISC_MEM, OPC_SYSTEM, OPC_OP, OPC_OP32;
  - imm_fmt_e enum.
- One combinational sub-module, riscv_imm_decode (instruction -> immediate, fmt, illegal). The top adds only the registers.

Test Plan:
- Reset: rst_n=0 for 2 cycles, with in_valid=1 and inst=0x00500093 -> out_valid=0, immediate=0, imm_fmt=NONE. Then release, apply addi 0x00500093 -> next cycle immediate=5, fmt=I.
- I-type sign: 0xFFF00113 -> 0xFFFF_FFFF_FFFF_FFFF; 0xF9C00493 -> 0xFFFF_FFFF_FFFF_FF9C; ld 0x00803183 -> 8; andi 0x0FF37293 -> 255.
- S/B/U/J:
  - sd 0x00323823 -> 16; sd 0x7EA5BFA3 -> 2047.
  - beq 0x00208463 -> 8.
  - lui 0x800000B7 -> 0xFFFF_FFFF_8000_0000.
  - jal 0x0080006F -> 8.
- Shifts: slli 0x00341393 -> 3, fmt=SHAMT; srai 0x4030D093 -> 3, not 0x403.
- Non-immediate: add 0x002081B3 -> 0, fmt=NONE. With IMM_ILLEGAL_EN, opcode 0x7F -> imm_illegal=1.
- Back-to-back and idle:
  - Apply a different instruction every cycle -> each result appears exactly one cycle later.
  - Drop in_valid -> out_valid=0 and immediate holds its last value.
  - Assert reset mid-stream -> outputs cleared on the next edge.

Source files
------------

// File: rtl/riscv_imm_gen_pkg.sv
// Shared opcode constants, immediate format codes and a sign-extension helper.
// Latency: none (declarations only).
// Backpressure: not applicable.
package riscv_imm_pkg;

    localparam int XLEN = 64;

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_OP32     = 7'b0111011;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_SRX = 3'b101;

    typedef enum logic [2:0] {
        FMT_NONE  = 3'd0,
        FMT_I     = 3'd1,
        FMT_S     = 3'd2,
        FMT_B     = 3'd3,
        FMT_U     = 3'd4,
        FMT_J     = 3'd5,
        FMT_SHAMT = 3'd6
    } imm_fmt_e;

    // Every signed format is assembled into 32 bits with inst[31] in bit 31,
    // so a single widening helper covers I/S/B/U/J.
    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return {{(XLEN-32){v[31]}}, v};
    endfunction

endpackage

// File: rtl/riscv_imm_gen_if.sv
// Decode-stage bus: instruction in, registered immediate/format out.
// Latency: none (wires only); the slave sees inputs, drives outputs.
// Backpressure: none; no ready signal exists. Optional IMM_ILLEGAL_EN adds imm_illegal.
interface riscv_imm_gen_if;
    import riscv_imm_pkg::*;

    logic            in_valid;
    logic [31:0]     instruction;
    logic            out_valid;
    logic [XLEN-1:0] immediate;
    imm_fmt_e        imm_fmt;
`ifdef IMM_ILLEGAL_EN
    logic            imm_illegal;
`endif

    modport master (
        output in_valid,
        output instruction,
        input  out_valid,
        input  immediate,
        input  imm_fmt
`ifdef IMM_ILLEGAL_EN
        , input imm_illegal
`endif
    );

    modport slave (
        input  in_valid,
        input  instruction,
        output out_valid,
        output immediate,
        output imm_fmt
`ifdef IMM_ILLEGAL_EN
        , output imm_illegal
`endif
    );

endinterface

// File: rtl/riscv_imm_gen_decode.sv
// Combinational RV64I immediate decoder: instruction -> immediate, format (and illegal with IMM_ILLEGAL_EN).
// Latency: 0 cycles, purely combinational.
// Backpressure: none.
module riscv_imm_decode
    import riscv_imm_pkg::*;
(
    input  logic [31:0]     instruction,
    output logic [XLEN-1:0] immediate,
    output imm_fmt_e        imm_fmt
`ifdef IMM_ILLEGAL_EN
    ,
    output logic            illegal
`endif
);

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            is_shift;
    logic            shift_hi_ok;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_b;
    logic [XLEN-1:0] imm_u;
    logic [XLEN-1:0] imm_j;
    logic [XLEN-1:0] imm_sh6;
    logic [XLEN-1:0] imm_sh5;
    logic            bad;

    assign opcode = instruction[6:0];
    assign funct3 = instruction[14:12];
    assign is_shift = (funct3 == F3_SLL) || (funct3 == F3_SRX);

    // Only SRAI may carry 010000 in its upper bits; SLLI/SRLI need all zeros.
    assign shift_hi_ok = (instruction[31:26] == 6'b000000) ||
                         ((funct3 == F3_SRX) && (instruction[31:26] == 6'b010000));

    // Candidate immediates for every format; the case below picks one.
    assign imm_i   = sext32({{20{instruction[31]}}, instruction[31:20]});
    assign imm_s   = sext32({{20{instruction[31]}}, instruction[31:25], instruction[11:7]});
    assign imm_b   = sext32({{19{instruction[31]}}, instruction[31], instruction[7],
                             instruction[30:25], instruction[11:8], 1'b0});
    assign imm_u   = sext32({instruction[31:12], 12'b0});
    assign imm_j   = sext32({{11{instruction[31]}}, instruction[31], instruction[19:12],
                             instruction[20], instruction[30:21], 1'b0});
    // Shift amounts are unsigned: 6 bits for 64-bit shifts, 5 bits for *W shifts.
    assign imm_sh6 = {{(XLEN-6){1'b0}}, instruction[25:20]};
    assign imm_sh5 = {{(XLEN-5){1'b0}}, instruction[24:20]};

    // Select format and immediate from the opcode; unknown opcodes give NONE/0.
    always_comb begin
        immediate = '0;
        imm_fmt   = FMT_NONE;
        bad       = 1'b0;
        unique case (opcode)
            OPC_LOAD, OPC_JALR, OPC_MISC_MEM, OPC_SYSTEM: begin
                immediate = imm_i;
                imm_fmt   = FMT_I;
            end
            OPC_OP_IMM: begin
                if (is_shift) begin
                    immediate = imm_sh6;
                    imm_fmt   = FMT_SHAMT;
                    bad       = !shift_hi_ok;
                end else begin
                    immediate = imm_i;
                    imm_fmt   = FMT_I;
                end
            end
            OPC_OP_IMM32: begin
                if (is_shift) begin
                    immediate = imm_sh5;
                    imm_fmt   = FMT_SHAMT;
                end else begin
                    immediate = imm_i;
                    imm_fmt   = FMT_I;
                end
            end
            OPC_STORE: begin
                immediate = imm_s;
                imm_fmt   = FMT_S;
            end
            OPC_BRANCH: begin
                immediate = imm_b;
                imm_fmt   = FMT_B;
            end
            OPC_LUI, OPC_AUIPC: begin
                immediate = imm_u;
                imm_fmt   = FMT_U;
            end
            OPC_JAL: begin
                immediate = imm_j;
                imm_fmt   = FMT_J;
            end
            // Register-register ops legitimately carry no immediate but are
            // still flagged, since nothing downstream should consume one.
            OPC_OP, OPC_OP32: begin
                bad = 1'b1;
            end
            default: begin
                bad = 1'b1;
            end
        endcase
    end

`ifdef IMM_ILLEGAL_EN
    assign illegal = bad;
`else
    // Without the illegal output the flag has no consumer.
    logic unused_bad;
    assign unused_bad = bad;
`endif

endmodule

// File: rtl/riscv_imm_gen.sv
// Registered RV64I immediate generator; optional imm_illegal output under IMM_ILLEGAL_EN.
// Latency: 1 cycle from in_valid/instruction to out_valid/immediate/imm_fmt.
// Backpressure: none; a word is accepted every cycle in_valid is high.
module riscv_imm_gen
    import riscv_imm_pkg::*;
#(
    parameter int XLEN_P = 64
) (
    input  logic           clk,
    input  logic           rst_n,
    riscv_imm_gen_if.slave bus
);

    logic [XLEN_P-1:0] dec_immediate;
    imm_fmt_e          dec_fmt;

    logic              out_valid_d;
    logic              out_valid_q;
    logic [XLEN_P-1:0] immediate_d;
    logic [XLEN_P-1:0] immediate_q;
    imm_fmt_e          imm_fmt_d;
    imm_fmt_e          imm_fmt_q;

`ifdef IMM_ILLEGAL_EN
    logic              dec_illegal;
    logic              imm_illegal_d;
    logic              imm_illegal_q;
`endif

    riscv_imm_decode u_decode (
        .instruction (bus.instruction),
        .immediate   (dec_immediate),
        .imm_fmt     (dec_fmt)
`ifdef IMM_ILLEGAL_EN
        ,
        .illegal     (dec_illegal)
`endif
    );

    // Capture a fresh decode only for valid words; otherwise hold the data.
    always_comb begin
        out_valid_d = bus.in_valid;
        immediate_d = immediate_q;
        imm_fmt_d   = imm_fmt_q;
        if (bus.in_valid) begin
            immediate_d = dec_immediate;
            imm_fmt_d   = dec_fmt;
        end
`ifdef IMM_ILLEGAL_EN
        // The flag qualifies the current word only, so it drops with in_valid.
        imm_illegal_d = bus.in_valid & dec_illegal;
`endif
    end

    // Output registers with synchronous reset that overrides any input.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            immediate_q <= '0;
            imm_fmt_q   <= FMT_NONE;
`ifdef IMM_ILLEGAL_EN
            imm_illegal_q <= 1'b0;
`endif
        end else begin
            out_valid_q <= out_valid_d;
            immediate_q <= immediate_d;
            imm_fmt_q   <= imm_fmt_d;
`ifdef IMM_ILLEGAL_EN
            imm_illegal_q <= imm_illegal_d;
`endif
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.immediate = immediate_q;
    assign bus.imm_fmt   = imm_fmt_q;
`ifdef IMM_ILLEGAL_EN
    assign bus.imm_illegal = imm_illegal_q;
`endif

endmodule

// File: tb/tb_riscv_imm_gen.sv
// Directed testbench for riscv_imm_gen; exercises imm_illegal when IMM_ILLEGAL_EN is defined.
// Latency: checks every result one clock after it is driven.
// Backpressure: none to model.
module tb_riscv_imm_gen;
    import riscv_imm_pkg::*;

    logic clk;
    logic rst_n;
    int   pass_cnt;
    int   total_cnt;

    riscv_imm_gen_if bus ();

    riscv_imm_gen dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one word before an edge, then settle just after that edge.
    task automatic drive(input logic v, input logic [31:0] inst);
        @(negedge clk);
        bus.in_valid    = v;
        bus.instruction = inst;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b1, 32'h00500093);
        drive(1'b1, 32'h00500093);
        total_cnt++;
        if (bus.out_valid !== 1'b0) $display("FAIL reset_valid got=%0b exp=0", bus.out_valid);
        else pass_cnt++;
        total_cnt++;
        if (bus.immediate !== 64'd0) $display("FAIL reset_imm got=%h exp=0", bus.immediate);
        else pass_cnt++;
        total_cnt++;
        if (bus.imm_fmt !== FMT_NONE) $display("FAIL reset_fmt got=%0d exp=0", bus.imm_fmt);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 32'h00500093);
        total_cnt++;
        if (bus.out_valid !== 1'b1 || bus.immediate !== 64'd5 || bus.imm_fmt !== FMT_I)
            $display("FAIL addi_after_reset got=%0b/%h/%0d exp=1/5/1",
                     bus.out_valid, bus.immediate, bus.imm_fmt);
        else pass_cnt++;
    endtask

    task automatic test_i_type();
        logic [31:0] ins [9] = '{32'hFFF00113, 32'hF9C00493, 32'h00803183, 32'h0FF37293,
                                 32'h7FF00013, 32'h80000013, 32'hFFC08067, 32'h00000073,
                                 32'hFFF0809B};
        logic [63:0] exp [9] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FF9C, 64'd8,
                                 64'd255, 64'd2047, 64'hFFFF_FFFF_FFFF_F800,
                                 64'hFFFF_FFFF_FFFF_FFFC, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF};
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, ins[i]);
            total_cnt++;
            if (bus.immediate !== exp[i] || bus.imm_fmt !== FMT_I)
                $display("FAIL i_type[%0d] inst=%h got=%h/%0d exp=%h/1",
                         i, ins[i], bus.immediate, bus.imm_fmt, exp[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_s_b_u_j();
        logic [31:0] ins [10] = '{32'h00323823, 32'h7EA5BFA3, 32'h00208463, 32'h80000063,
                                  32'h7E000FE3, 32'h800000B7, 32'h00001097, 32'h0080006F,
                                  32'h8000006F, 32'h7FFFF06F};
        logic [63:0] exp [10] = '{64'd16, 64'd2047, 64'd8, 64'hFFFF_FFFF_FFFF_F000, 64'd4094,
                                  64'hFFFF_FFFF_8000_0000, 64'h1000, 64'd8,
                                  64'hFFFF_FFFF_FFF0_0000, 64'd1048574};
        imm_fmt_e    fmt [10] = '{FMT_S, FMT_S, FMT_B, FMT_B, FMT_B, FMT_U, FMT_U, FMT_J,
                                  FMT_J, FMT_J};
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, ins[i]);
            total_cnt++;
            if (bus.immediate !== exp[i] || bus.imm_fmt !== fmt[i])
                $display("FAIL sbuj[%0d] inst=%h got=%h/%0d exp=%h/%0d",
                         i, ins[i], bus.immediate, bus.imm_fmt, exp[i], fmt[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_shifts();
        // slli, srai (upper funct7 must not leak), slliw with bit25 set (5-bit shamt)
        logic [31:0] ins [3] = '{32'h00341393, 32'h4030D093, 32'h0230909B};
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, ins[i]);
            total_cnt++;
            if (bus.immediate !== 64'd3 || bus.imm_fmt !== FMT_SHAMT)
                $display("FAIL shamt[%0d] inst=%h got=%h/%0d exp=3/6",
                         i, ins[i], bus.immediate, bus.imm_fmt);
            else pass_cnt++;
        end
    endtask

    task automatic test_none();
        logic [31:0] ins [3] = '{32'h002081B3, 32'h002081BB, 32'hFFFFFFFF};
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, ins[i]);
            total_cnt++;
            if (bus.immediate !== 64'd0 || bus.imm_fmt !== FMT_NONE || bus.out_valid !== 1'b1)
                $display("FAIL none[%0d] inst=%h got=%h/%0d exp=0/0",
                         i, ins[i], bus.immediate, bus.imm_fmt);
            else pass_cnt++;
        end
    endtask

`ifdef IMM_ILLEGAL_EN
    task automatic test_illegal();
        logic [31:0] ins [6] = '{32'h0000007F, 32'h002081B3, 32'h00500093, 32'h4030D093,
                                 32'h40341393, 32'h8030D093};
        logic        exp [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, ins[i]);
            total_cnt++;
            if (bus.imm_illegal !== exp[i])
                $display("FAIL illegal[%0d] inst=%h got=%0b exp=%0b",
                         i, ins[i], bus.imm_illegal, exp[i]);
            else pass_cnt++;
        end
        drive(1'b0, 32'h0000007F);
        total_cnt++;
        if (bus.imm_illegal !== 1'b0) $display("FAIL illegal_idle got=%0b exp=0", bus.imm_illegal);
        else pass_cnt++;
    endtask
`endif

    task automatic test_back_to_back();
        logic [31:0] ins [5] = '{32'h00500093, 32'h00323823, 32'h800000B7, 32'h00341393,
                                 32'h0080006F};
        logic [63:0] exp [5] = '{64'd5, 64'd16, 64'hFFFF_FFFF_8000_0000, 64'd3, 64'd8};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.in_valid    = 1'b1;
            bus.instruction = ins[i];
            #1;
            // Freshly applied word must not be visible before the edge.
            if (i > 0) begin
                total_cnt++;
                if (bus.immediate !== exp[i-1] || bus.out_valid !== 1'b1)
                    $display("FAIL b2b_pre[%0d] got=%h exp=%h", i, bus.immediate, exp[i-1]);
                else pass_cnt++;
            end
            @(posedge clk);
            #1;
            total_cnt++;
            if (bus.immediate !== exp[i] || bus.out_valid !== 1'b1)
                $display("FAIL b2b_post[%0d] got=%h exp=%h", i, bus.immediate, exp[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_idle();
        // Last result from back-to-back is jal -> 8, fmt J.
        drive(1'b0, 32'h80000063);
        drive(1'b0, 32'hFFF00113);
        total_cnt++;
        if (bus.out_valid !== 1'b0) $display("FAIL idle_valid got=%0b exp=0", bus.out_valid);
        else pass_cnt++;
        total_cnt++;
        if (bus.immediate !== 64'd8 || bus.imm_fmt !== FMT_J)
            $display("FAIL idle_hold got=%h/%0d exp=8/5", bus.immediate, bus.imm_fmt);
        else pass_cnt++;
    endtask

    task automatic test_mid_reset();
        drive(1'b1, 32'hFFF00113);
        @(negedge clk);
        rst_n           = 1'b0;
        bus.in_valid    = 1'b1;
        bus.instruction = 32'h7FFFF06F;
        @(posedge clk);
        #1;
        total_cnt++;
        if (bus.out_valid !== 1'b0 || bus.immediate !== 64'd0 || bus.imm_fmt !== FMT_NONE)
            $display("FAIL mid_reset got=%0b/%h/%0d exp=0/0/0",
                     bus.out_valid, bus.immediate, bus.imm_fmt);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 32'hF9C00493);
        total_cnt++;
        if (bus.out_valid !== 1'b1 || bus.immediate !== 64'hFFFF_FFFF_FFFF_FF9C || bus.imm_fmt !== FMT_I)
            $display("FAIL post_reset got=%0b/%h/%0d exp=1/ffffffffffffff9c/1",
                     bus.out_valid, bus.immediate, bus.imm_fmt);
        else pass_cnt++;
    endtask

    initial begin
        pass_cnt        = 0;
        total_cnt       = 0;
        rst_n           = 1'b0;
        bus.in_valid    = 1'b0;
        bus.instruction = 32'h0;
        test_reset();
        test_i_type();
        test_s_b_u_j();
        test_shifts();
        test_none();
`ifdef IMM_ILLEGAL_EN
        test_illegal();
`endif
        test_back_to_back();
        test_idle();
        test_mid_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
